// File: rtl/shift_pkg.sv
// Purpose : shared opcodes, shift-register mode codes and sequencer state type.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

   // Command opcodes
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_ASR  = 3'b110;
   localparam logic [2:0] OP_ILL  = 3'b111;

   // Shift register {S1,S0} mode codes
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_SHR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   // True for the five ops that walk through SHIFT.
   function automatic logic is_shift_op(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
             (op == OP_ROR) || (op == OP_ASR);
   endfunction

   // Left-moving ops shift out the MSB; all others shift out the LSB.
   function automatic logic is_left_op(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_ROL);
   endfunction

endpackage

// File: rtl/ShiftParallel_NBIT.sv
// Purpose : N-bit universal shift register (hold / parallel load / shift left / shift right).
// Latency : qout updates on the clk edge following a non-hold mode.
// Backpressure: none; no reset, contents persist while {S1,S0}=00.
// Ports: clk; din (parallel data); din_left (MSB fill on right shift);
//        din_right (LSB fill on left shift); S0/S1 (mode); qout (register).
module ShiftParallel_NBIT #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic [N-1:0] din,
   input  logic         din_left,
   input  logic         din_right,
   input  logic         S0,
   input  logic         S1,
   output logic [N-1:0] qout
);

   always_ff @(posedge clk) begin
      case ({S1, S0})
         2'b01:   qout <= din;
         2'b10:   qout <= {qout[N-2:0], din_right};
         2'b11:   qout <= {din_left, qout[N-1:1]};
         default: qout <= qout;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Purpose : expands load/shift/rotate/ASR commands into per-cycle shift register controls.
// Latency : LOAD 1 edge after accept, shift-by-N N edges after accept; done the cycle after.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is ignored.
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready handshake with
//        cmd_op/cmd_data/cmd_amt/cmd_fill; sr_q feedback from the register;
//        sr_din/sr_din_left/sr_din_right/sr_s0/sr_s1 to the register;
//        busy, done, err (with done), last_out (last bit shifted out).
module shift_seq_ctrl
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_amt,
   input  logic             cmd_fill,
   input  logic [WIDTH-1:0] sr_q,
   output logic [WIDTH-1:0] sr_din,
   output logic             sr_din_left,
   output logic             sr_din_right,
   output logic             sr_s0,
   output logic             sr_s1,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             last_out
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fill;
   logic             r_last_out;
   logic [1:0]       w_mode;

   // Only the end bits of sr_q feed the fill mux; fold the rest away.
   logic             w_unused_q;
   assign w_unused_q = ^sr_q;

   // ---------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_op       <= OP_NOP;
         r_data     <= '0;
         r_cnt      <= '0;
         r_fill     <= 1'b0;
         r_last_out <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_op   <= cmd_op;
                  r_data <= cmd_data;
                  r_cnt  <= cmd_amt;
                  r_fill <= cmd_fill;
               end
            end
            ST_SHIFT: begin
               r_cnt      <= r_cnt - 1'b1;
               // Capture the bit leaving the register on this step.
               r_last_out <= is_left_op(r_op) ? sr_q[WIDTH-1] : sr_q[0];
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_op == OP_LOAD)
                  w_state_nxt = ST_LOAD;
               else if (is_shift_op(cmd_op) && (cmd_amt != '0))
                  w_state_nxt = ST_SHIFT;
               else
                  // NOP, zero-length shift and illegal op all finish at once.
                  w_state_nxt = ST_DONE;
            end
         end
         ST_LOAD:  w_state_nxt = ST_DONE;
         ST_SHIFT: begin
            if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1})
               w_state_nxt = ST_DONE;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Output decode; fills alone look at live sr_q so rotates and ASR
   // track the register value of the current cycle.
   // ---------------------------------------------------------------
   always_comb begin
      w_mode       = MODE_HOLD;
      sr_din       = '0;
      sr_din_left  = 1'b0;
      sr_din_right = 1'b0;
      cmd_ready    = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      err          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_LOAD: begin
            w_mode = MODE_LOAD;
            sr_din = r_data;
         end
         ST_SHIFT: begin
            case (r_op)
               OP_SHL: begin
                  w_mode       = MODE_SHL;
                  sr_din_right = r_fill;
               end
               OP_SHR: begin
                  w_mode      = MODE_SHR;
                  sr_din_left = r_fill;
               end
               OP_ROL: begin
                  w_mode       = MODE_SHL;
                  sr_din_right = sr_q[WIDTH-1];
               end
               OP_ROR: begin
                  w_mode      = MODE_SHR;
                  sr_din_left = sr_q[0];
               end
               OP_ASR: begin
                  w_mode      = MODE_SHR;
                  sr_din_left = sr_q[WIDTH-1];
               end
               default: w_mode = MODE_HOLD;
            endcase
         end
         ST_DONE: begin
            done = 1'b1;
            err  = (r_op == OP_ILL);
         end
         default: busy = 1'b0;
      endcase
   end

   assign sr_s1    = w_mode[1];
   assign sr_s0    = w_mode[0];
   assign last_out = r_last_out;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Purpose : scoreboard bench for shift_seq_ctrl driving ShiftParallel_NBIT.
// Latency : checks per-step qout, done latency, busy length and reset abort.
// Backpressure: waits on cmd_ready (bounded) before each command.
module tb_shift_seq_ctrl;
   import shift_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_amt;
   logic             cmd_fill;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_din;
   logic             sr_din_left, sr_din_right, sr_s0, sr_s1;
   logic             busy, done, err, last_out;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt), .cmd_fill(cmd_fill),
      .sr_q(sr_q), .sr_din(sr_din), .sr_din_left(sr_din_left), .sr_din_right(sr_din_right),
      .sr_s0(sr_s0), .sr_s1(sr_s1),
      .busy(busy), .done(done), .err(err), .last_out(last_out)
   );

   ShiftParallel_NBIT #(.N(WIDTH)) u_sr (
      .clk(clk), .din(sr_din), .din_left(sr_din_left), .din_right(sr_din_right),
      .S0(sr_s0), .S1(sr_s1), .qout(sr_q)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [WIDTH-1:0] q;
      logic             err;
      logic             last;
   } exp_t;

   exp_t             res_q[$];
   logic [WIDTH-1:0] step_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Step monitor: every edge taken with a non-hold mode must move qout
   // to the next hand-computed value.
   logic [1:0] mode_neg = 2'b00;
   always @(negedge clk) mode_neg = {sr_s1, sr_s0};

   always @(posedge clk) begin : step_mon
      logic [1:0]       m;
      logic [WIDTH-1:0] e;
      m = mode_neg;
      #1;
      if (m != 2'b00) begin
         if (step_q.size() == 0) begin
            check("unexpected_step_mode", {30'd0, m}, 32'd0);
         end else begin
            e = step_q.pop_front();
            check("qout_step", {24'd0, sr_q}, {24'd0, e});
         end
      end
   end

   // Completion monitor: each done pulse retires one expected result.
   always @(negedge clk) begin : done_mon
      exp_t x;
      if (done === 1'b1) begin
         if (res_q.size() == 0) begin
            check("unexpected_done", {31'd0, done}, 32'd0);
         end else begin
            x = res_q.pop_front();
            check("done_qout", {24'd0, sr_q}, {24'd0, x.q});
            check("done_err", {31'd0, err}, {31'd0, x.err});
            check("done_last_out", {31'd0, last_out}, {31'd0, x.last});
         end
      end else if (err === 1'b1) begin
         check("err_without_done", {31'd0, err}, 32'd0);
      end
   end

   // Issue one command and follow it to completion; called at a negedge.
   task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] data,
                          input logic [CNT_W-1:0] amt, input logic fill,
                          input logic [WIDTH-1:0] eq, input logic ee, input logic el,
                          input int exp_lat, input int exp_busy);
      int guard, lat, nbusy, ndone;
      exp_t x;
      x.q = eq; x.err = ee; x.last = el;
      res_q.push_back(x);
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
         return;
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_amt = amt; cmd_fill = fill;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      lat = -1; nbusy = 0; ndone = 0; guard = 0;
      do begin
         @(negedge clk);
         if (busy === 1'b1) nbusy++;
         if (done === 1'b1) begin
            ndone++;
            if (lat < 0) lat = guard;
         end
         guard++;
      end while (busy === 1'b1 && guard < 40);
      if (guard >= 40) check("busy_timeout", {31'd0, busy}, 32'd0);
      check("done_latency", lat, exp_lat);
      check("busy_cycles", nbusy, exp_busy);
      check("done_width", ndone, 1);
   endtask

   task automatic push_steps(input logic [WIDTH-1:0] v[]);
      foreach (v[i]) step_q.push_back(v[i]);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0; cmd_amt = '0; cmd_fill = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_mode", {30'd0, sr_s1, sr_s0}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      #1;
      check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      check("reset_last_out", {31'd0, last_out}, 32'd0);
      check("reset_sr_din", {24'd0, sr_din}, 32'd0);
      check("reset_fills", {30'd0, sr_din_left, sr_din_right}, 32'd0);
      @(negedge clk);

      // LOAD then SHL by 2 with fill 1
      push_steps('{8'h0F});
      run_cmd(OP_LOAD, 8'h0F, 4'd0, 1'b0, 8'h0F, 1'b0, 1'b0, 1, 2);
      push_steps('{8'h1F, 8'h3F});
      run_cmd(OP_SHL, 8'h00, 4'd2, 1'b1, 8'h3F, 1'b0, 1'b0, 2, 3);

      // Rotate left by 9 wraps to a rotate by 1; MSB 1 leaves last
      push_steps('{8'h81});
      run_cmd(OP_LOAD, 8'h81, 4'd0, 1'b0, 8'h81, 1'b0, 1'b0, 1, 2);
      push_steps('{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03});
      run_cmd(OP_ROL, 8'h00, 4'd9, 1'b0, 8'h03, 1'b0, 1'b1, 9, 10);

      // LOAD keeps last_out; ROR by 3 clears it
      push_steps('{8'h81});
      run_cmd(OP_LOAD, 8'h81, 4'd0, 1'b0, 8'h81, 1'b0, 1'b1, 1, 2);
      push_steps('{8'hC0, 8'h60, 8'h30});
      run_cmd(OP_ROR, 8'h00, 4'd3, 1'b1, 8'h30, 1'b0, 1'b0, 3, 4);

      // ASR sign fill, then logical right flush past WIDTH
      push_steps('{8'h90});
      run_cmd(OP_LOAD, 8'h90, 4'd0, 1'b0, 8'h90, 1'b0, 1'b0, 1, 2);
      push_steps('{8'hC8, 8'hE4});
      run_cmd(OP_ASR, 8'h00, 4'd2, 1'b0, 8'hE4, 1'b0, 1'b0, 2, 3);
      push_steps('{8'h72, 8'h39, 8'h1C, 8'h0E, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00});
      run_cmd(OP_SHR, 8'h00, 4'd9, 1'b0, 8'h00, 1'b0, 1'b0, 9, 10);

      // Zero-length shift and illegal op complete immediately
      run_cmd(OP_SHL, 8'hAA, 4'd0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1);
      run_cmd(OP_ILL, 8'hAA, 4'd3, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1);

      // SHR with fill 1 from zero
      push_steps('{8'h80, 8'hC0});
      run_cmd(OP_SHR, 8'h00, 4'd2, 1'b1, 8'hC0, 1'b0, 1'b0, 2, 3);

      // Reset mid-command: abort after 3 of 8 shift steps
      push_steps('{8'hFF});
      run_cmd(OP_LOAD, 8'hFF, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 1, 2);
      push_steps('{8'hFE, 8'hFC, 8'hF8});
      cmd_valid = 1'b1; cmd_op = OP_SHL; cmd_data = '0; cmd_amt = 4'd8; cmd_fill = 1'b0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_mode", {30'd0, sr_s1, sr_s0}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      check("abort_qout_hold", {24'd0, sr_q}, 32'h0000_00F8);
      rst = 1'b0;
      #1;
      check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("abort_last_out", {31'd0, last_out}, 32'd0);
      repeat (4) @(negedge clk);
      check("post_abort_qout", {24'd0, sr_q}, 32'h0000_00F8);
      check("post_abort_busy", {31'd0, busy}, 32'd0);

      check("steps_left", step_q.size(), 32'd0);
      check("results_left", res_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
